// File: rtl/maze_step_tracker_if.sv
// Command/response channel of the maze position tracker.
// Latency: n/a (signal bundle only).
// Backpressure: cmd_ready gates cmd_valid; responses are single-cycle pulses with no stall.
interface maze_step_tracker_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ret;
    logic [1:0] cmd_dir;
    logic       rsp_valid;
    logic       blocked;

    // Command issuer: drives commands, observes readiness and results.
    modport master (
        output cmd_valid, cmd_ret, cmd_dir,
        input  cmd_ready, rsp_valid, blocked
    );

    // Tracker: consumes commands, produces readiness and results.
    modport slave (
        input  cmd_valid, cmd_ret, cmd_dir,
        output cmd_ready, rsp_valid, blocked
    );
endinterface

// File: rtl/maze_step_tracker.sv
// Maze position tracker: steps (row, colomn) one cell per command and undoes moves from a backtrack stack.
// Latency: position, rsp_valid and blocked update on the edge that accepts the command.
// Backpressure: cmd_ready drops for the response cycle, so at most one command every two cycles.
module maze_step_tracker #(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int N_ROWS      = 16,
    parameter int N_COLS      = 16,
    parameter int STACK_DEPTH = 64,
    parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ROW_W-1:0]   start_row,
    input  logic [COL_W-1:0]   start_colomn,
    maze_step_tracker_if.slave cmd,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   colomn,
    output logic [DW-1:0]      depth,
    output logic               empty,
    output logic               full,
    output logic               at_goal
);

    // Stack index width; kept at least one bit so a depth-1 stack still has an address.
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    // Two extra bits: one for the sign (0-1 must be seen as negative) and one so
    // that 2**W (one past the last cell of a full-width maze) does not wrap.
    localparam int RW = ROW_W + 2;
    localparam int CW = COL_W + 2;
    localparam logic signed [RW-1:0] ROW_LIM = RW'(N_ROWS);
    localparam logic signed [CW-1:0] COL_LIM = CW'(N_COLS);

    typedef enum logic [1:0] {IDLE, READY, RESP} state_t;

    state_t           state;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    logic [DW-1:0]    depth_q;
    logic             ready_q;
    logic             rsp_q;
    logic             blk_q;

    logic [1:0] stack [STACK_DEPTH];

    logic [DW-1:0]          depth_m1;
    logic [1:0]             top_dir;
    logic [1:0]             eff_dir;
    logic signed [RW-1:0]   d_row;
    logic signed [CW-1:0]   d_col;
    logic signed [RW-1:0]   cand_row;
    logic signed [CW-1:0]   cand_col;
    logic                   oob;
    logic                   blk;
    logic                   accept;
    logic                   push;

    assign empty   = (depth_q == '0);
    assign full    = (depth_q == DW'(STACK_DEPTH));
    assign at_goal = (row_q == ROW_W'(N_ROWS - 1)) && (col_q == COL_W'(N_COLS - 1));

    assign row           = row_q;
    assign colomn        = col_q;
    assign depth         = depth_q;
    assign cmd.cmd_ready = ready_q;
    assign cmd.rsp_valid = rsp_q;
    assign cmd.blocked   = blk_q;

    // start wins over a command presented in the same cycle.
    assign accept   = (state == READY) && cmd.cmd_valid && !start;
    assign push     = accept && !cmd.cmd_ret && !blk;
    assign depth_m1 = depth_q - DW'(1);

    // Candidate position and rejection decision for the command at the input.
    always_comb begin
        top_dir = stack[depth_m1[AW-1:0]];
        // Undoing direction d means moving in ~d: 0<->3 and 1<->2.
        eff_dir = cmd.cmd_ret ? ~top_dir : cmd.cmd_dir;
        d_row   = '0;
        d_col   = '0;
        case (eff_dir)
            2'd0:    d_col = CW'(1);
            2'd1:    d_row = RW'(1);
            2'd2:    d_row = {RW{1'b1}};
            default: d_col = {CW{1'b1}};
        endcase
        cand_row = $signed({2'b00, row_q}) + d_row;
        cand_col = $signed({2'b00, col_q}) + d_col;
        oob      = cand_row[RW-1] || (cand_row >= ROW_LIM) ||
                   cand_col[CW-1] || (cand_col >= COL_LIM);
        // A pop always lands on a previously visited cell, so only emptiness matters.
        blk      = cmd.cmd_ret ? empty : (oob || full);
    end

    // Control FSM with registered handshake outputs, position and depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            depth_q <= '0;
            ready_q <= 1'b0;
            rsp_q   <= 1'b0;
            blk_q   <= 1'b0;
        end else if (start) begin
            state   <= READY;
            row_q   <= start_row;
            col_q   <= start_colomn;
            depth_q <= '0;
            ready_q <= 1'b1;
            rsp_q   <= 1'b0;
            blk_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    rsp_q   <= 1'b0;
                end
                READY: begin
                    if (accept) begin
                        state   <= RESP;
                        ready_q <= 1'b0;
                        rsp_q   <= 1'b1;
                        blk_q   <= blk;
                        if (!blk) begin
                            row_q   <= cand_row[ROW_W-1:0];
                            col_q   <= cand_col[COL_W-1:0];
                            depth_q <= cmd.cmd_ret ? depth_m1 : depth_q + DW'(1);
                        end
                    end
                end
                RESP: begin
                    state   <= READY;
                    ready_q <= 1'b1;
                    rsp_q   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    rsp_q   <= 1'b0;
                end
            endcase
        end
    end

    // Backtrack stack storage; contents are don't-care after reset or start.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[depth_q[AW-1:0]] <= cmd.cmd_dir;
        end
    end

endmodule
